// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory request feeding a prefetch FIFO,
// with redirect handling that drops the data of a request still in flight.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     imem_req,
   output logic [31:0]              imem_addr,
   input  logic                     imem_ack,
   input  logic [31:0]              imem_rdata,
   output logic [31:0]              instruction,
   output logic [31:0]              instr_pc,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int            AW   = $clog2(DEPTH);
   localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   data_mem [DEPTH];

   logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   tgt_q, tgt_d;
   logic          pend_q, pend_d;
   logic          drop_q, drop_d;
   logic [31:0]   redir_al;
   logic          done, push, pop;

   assign redir_al    = redirect_pc & ~32'h3;
   // A request already on the bus stays up regardless of redirect or FIFO level.
   assign imem_req    = !reset && (pend_q || (count_q != FULL && !redirect));
   assign imem_addr   = fetch_pc_q;
   assign done        = imem_req && imem_ack;
   assign instr_valid = (count_q != '0);
   assign instruction = instr_valid ? data_mem[rd_ptr_q] : '0;
   assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q]   : '0;
   assign fifo_count  = count_q;

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      fetch_pc_d = fetch_pc_q;
      tgt_d      = tgt_q;
      drop_d     = drop_q;
      pend_d     = imem_req && !imem_ack;
      push       = 1'b0;
      pop        = 1'b0;
      if (redirect) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         if (imem_req && !imem_ack) begin
            // Old address stays on the bus; the new target waits for its ack.
            drop_d = 1'b1;
            tgt_d  = redir_al;
         end else begin
            drop_d     = 1'b0;
            fetch_pc_d = redir_al;
         end
      end else if (drop_q) begin
         if (done) begin
            drop_d     = 1'b0;
            fetch_pc_d = tgt_q;
         end
      end else begin
         push = done;
         pop  = instr_valid && instr_ready;
         if (push) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         fetch_pc_q <= RESET_PC;
         tgt_q      <= RESET_PC;
         pend_q     <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         fetch_pc_q <= fetch_pc_d;
         tgt_q      <= tgt_d;
         pend_q     <= pend_d;
         drop_q     <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]   <= fetch_pc_q;
         data_mem[wr_ptr_q] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written corner sequences,
// and a randomized run against a queue-based reference model.
module tb_instr_fetch;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] KEY      = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req, imem_ack, instr_valid, instr_ready, redirect;
   logic [31:0] imem_addr, imem_rdata, instruction, instr_pc, redirect_pc;
   logic [2:0]  fifo_count;
   logic        use_rand;
   logic [31:0] rnd_data;

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   assign imem_rdata = use_rand ? rnd_data : (imem_addr ^ KEY);

   instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
      .fifo_count(fifo_count)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic setin(input bit rd, input logic [31:0] rpc, input bit ack, input bit rdy);
      redirect    = rd;
      redirect_pc = rpc;
      imem_ack    = ack;
      instr_ready = rdy;
   endtask

   // Leaves the bench at a negedge, first cycle out of reset, ready for inputs.
   task automatic do_reset();
      reset = 1'b1;
      setin(0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic chk_out(input string nm, input bit req, input logic [31:0] addr,
                          input bit vld, input logic [31:0] pc, input int cnt);
      chk({nm, ".req"},   32'(imem_req),    32'(req));
      if (req) chk({nm, ".addr"}, imem_addr, addr);
      chk({nm, ".valid"}, 32'(instr_valid), 32'(vld));
      chk({nm, ".pc"},    instr_pc,         vld ? pc : 32'h0);
      chk({nm, ".instr"}, instruction,      vld ? (pc ^ KEY) : 32'h0);
      chk({nm, ".count"}, 32'(fifo_count),  32'(cnt));
   endtask

   typedef struct {
      bit          rd;
      logic [31:0] rpc;
      bit          ack, rdy;
      bit          e_req;
      logic [31:0] e_addr;
      bit          e_vld;
      logic [31:0] e_pc;
      int          e_cnt;
   } vec_t;

   vec_t tbl [9];

   typedef struct { logic [31:0] pc, d; } ent_t;
   ent_t        mq[$];
   logic [31:0] m_fpc, m_tgt;
   bit          m_pend, m_drop;

   initial begin
      use_rand = 1'b0;
      rnd_data = '0;

      // Redirect while a request is stalled: old address held, its data dropped.
      tbl[0] = '{0, 32'h0,   1, 0, 1, 32'h0,   0, 32'h0,   0};
      tbl[1] = '{0, 32'h0,   1, 0, 1, 32'h4,   1, 32'h0,   1};
      tbl[2] = '{0, 32'h0,   0, 0, 1, 32'h8,   1, 32'h0,   2};
      tbl[3] = '{1, 32'h103, 0, 0, 1, 32'h8,   1, 32'h0,   2};
      tbl[4] = '{0, 32'h0,   0, 0, 1, 32'h8,   0, 32'h0,   0};
      tbl[5] = '{0, 32'h0,   1, 0, 1, 32'h8,   0, 32'h0,   0};
      tbl[6] = '{0, 32'h0,   1, 1, 1, 32'h100, 0, 32'h0,   0};
      tbl[7] = '{0, 32'h0,   0, 1, 1, 32'h104, 1, 32'h100, 1};
      tbl[8] = '{0, 32'h0,   0, 0, 1, 32'h104, 0, 32'h0,   0};

      // Reset state
      reset = 1'b1;
      setin(0, 0, 0, 0);
      #12;
      chk_out("reset", 0, 0, 0, 0, 0);

      do_reset();
      foreach (tbl[i]) begin
         setin(tbl[i].rd, tbl[i].rpc, tbl[i].ack, tbl[i].rdy);
         #1;
         chk_out($sformatf("tbl%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld, tbl[i].e_pc, tbl[i].e_cnt);
         @(negedge clk);
      end

      // Backpressure, full-FIFO redirect with pop, then address wrap.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         setin(0, 0, 1, 0); #1;
         chk_out($sformatf("fill%0d", k), 1, 32'(4*k), k != 0, 32'h0, k);
         @(negedge clk);
      end
      setin(0, 0, 1, 1); #1; chk_out("full", 0, 0, 1, 32'h0, 4); @(negedge clk);
      setin(0, 0, 1, 0); #1; chk_out("refill", 1, 32'h10, 1, 32'h4, 3); @(negedge clk);
      setin(1, 32'h200, 1, 1); #1; chk_out("full_redir", 0, 0, 1, 32'h4, 4); @(negedge clk);
      setin(0, 0, 1, 1); #1; chk_out("post_redir", 1, 32'h200, 0, 0, 0); @(negedge clk);
      setin(1, 32'hFFFF_FFFE, 1, 1); #1; chk_out("wrap_redir", 0, 0, 1, 32'h200, 1); @(negedge clk);
      setin(0, 0, 1, 1); #1; chk_out("wrap0", 1, 32'hFFFF_FFFC, 0, 0, 0); @(negedge clk);
      setin(0, 0, 1, 1); #1; chk_out("wrap1", 1, 32'h0, 1, 32'hFFFF_FFFC, 1); @(negedge clk);
      setin(0, 0, 1, 1); #1; chk_out("wrap2", 1, 32'h4, 1, 32'h0, 1); @(negedge clk);

      // Streaming then asynchronous reset between edges.
      do_reset();
      for (int k = 0; k < 8; k++) begin
         setin(0, 0, 1, 1); #1;
         chk_out($sformatf("stream%0d", k), 1, 32'(4*k), k != 0, 32'(4*(k-1)), k != 0 ? 1 : 0);
         @(negedge clk);
      end
      #2 reset = 1'b1;
      #1 chk_out("async_rst", 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk_out("after_rst", 1, RESET_PC, 0, 0, 0);
      @(negedge clk);

      // Randomized run against the reference model.
      do_reset();
      use_rand = 1'b1;
      mq.delete();
      m_fpc = RESET_PC; m_tgt = '0; m_pend = 0; m_drop = 0;
      for (int c = 0; c < 3000; c++) begin
         bit          m_req, dn;
         logic [31:0] al;
         setin($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
         rnd_data = $urandom;
         #1;
         m_req = m_pend || (mq.size() < DEPTH && !redirect);
         chk("rnd.req", 32'(imem_req), 32'(m_req));
         if (m_req) chk("rnd.addr", imem_addr, m_fpc);
         chk("rnd.valid", 32'(instr_valid), 32'(mq.size() != 0));
         chk("rnd.pc",    instr_pc,    mq.size() != 0 ? mq[0].pc : 32'h0);
         chk("rnd.instr", instruction, mq.size() != 0 ? mq[0].d  : 32'h0);
         chk("rnd.count", 32'(fifo_count), 32'(mq.size()));
         @(posedge clk);
         dn = m_req && imem_ack;
         al = {redirect_pc[31:2], 2'b00};
         if (redirect) begin
            mq.delete();
            if (m_req && !imem_ack) begin m_drop = 1; m_tgt = al; end
            else begin m_drop = 0; m_fpc = al; end
         end else if (m_drop) begin
            if (dn) begin m_drop = 0; m_fpc = m_tgt; end
         end else begin
            if (mq.size() != 0 && instr_ready) void'(mq.pop_front());
            if (dn) begin mq.push_back('{m_fpc, imem_rdata}); m_fpc = m_fpc + 32'd4; end
         end
         m_pend = m_req && !imem_ack;
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
